cdb_arbiter: RTL and testbench

- Arbitrates the common data bus (CDB) between functional units (adders, multipliers, loaders, storers, branch) that have finished computing and hold a result for a reorder-buffer entry.
- Grants up to CDB_PORTS results per cycle, round-robin across FUs.
- Registers the winners onto the packed per-RB-entry buses CDB_data_data / CDB_data_addr / CDB_data_valid that the reorder buffer samples at negedge.
- Drops results from FUs squashed by a branch flush.

---
 rtl/cdb_arbiter_pkg.sv | 29 ++
 rtl/cdb_arbiter_rr_picker.sv | 39 +++
 rtl/cdb_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared sizing and FU-map constants for the common-data-bus arbiter.
// Default top parameters and the round-robin pointer helper live here.
package cdb_arbiter_pkg;

  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 8;
  localparam int RB_INDEX  = 3;
  localparam int FU_NUM    = 8;
  localparam int FU_INDEX  = 4;

  // FU numbering: requester slot i of the arbiter is FU i.
  localparam int ADDER_START  = 0;
  localparam int ADDER_NUM    = 2;
  localparam int MULTER_START = 2;
  localparam int MULTER_NUM   = 2;
  localparam int LOADER_START = 4;
  localparam int LOADER_NUM   = 2;
  localparam int STORER_START = 6;
  localparam int STORER_NUM   = 1;
  localparam int BRANCH_START = 7;
  localparam int BRANCH_NUM   = 1;

  localparam logic [FU_INDEX-1:0] NO_FU = '1;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational circular first-one finder: scans from start_i upward, wrapping,
// over requests not masked by excl_i; returns a one-hot grant and a found flag.
module cdb_arbiter_rr_picker
  import cdb_arbiter_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  gnt_o,
  output logic          found_o
);

  logic [N-1:0] masked;
  logic         hit;

  always_comb begin
    masked = req_i & ~excl_i;
    gnt_o  = '0;
    hit    = 1'b0;
    // Upper segment [start, N) first, then the wrapped segment [0, start).
    for (int i = 0; i < N; i++) begin
      if (!hit && masked[i] && (i >= int'(start_i))) begin
        gnt_o[i] = 1'b1;
        hit      = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && masked[i]) begin
        gnt_o[i] = 1'b1;
        hit      = 1'b1;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to CDB_PORTS finished FU results per cycle
// and registers the winners onto per-RB-entry broadcast slots for one cycle.
module cdb_arbiter #(
  parameter int WORD_SIZE = cdb_arbiter_pkg::WORD_SIZE,
  parameter int RB_SIZE   = cdb_arbiter_pkg::RB_SIZE,
  parameter int RB_INDEX  = cdb_arbiter_pkg::RB_INDEX,
  parameter int FU_NUM    = cdb_arbiter_pkg::FU_NUM,
  parameter int FU_INDEX  = cdb_arbiter_pkg::FU_INDEX,
  parameter int CDB_PORTS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FU_NUM-1:0]             req,
  input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
  input  logic [FU_NUM*WORD_SIZE-1:0]   req_addr,
  input  logic [FU_NUM*RB_INDEX-1:0]    req_rbidx,
  input  logic [FU_NUM-1:0]             flush,
  output logic [FU_NUM-1:0]             grant,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic                          cdb_busy
);
  import cdb_arbiter_pkg::*;

  logic [WORD_SIZE-1:0]         data_a  [FU_NUM];
  logic [WORD_SIZE-1:0]         addr_a  [FU_NUM];
  logic [RB_INDEX-1:0]          rbidx_a [FU_NUM];
  logic [FU_NUM-1:0]            eff, g0, g1;
  logic                         f0, f1;
  logic [FU_INDEX-1:0]          start1, nxt1;
  logic [RB_INDEX-1:0]          rb0, rb1;
  logic [WORD_SIZE-1:0]         d0, d1, a0, a1;

  logic [FU_INDEX-1:0]          rr_ptr_q, rr_ptr_d;
  logic [RB_SIZE-1:0]           valid_q, valid_d;
  logic [RB_SIZE*WORD_SIZE-1:0] data_q, data_d, addr_q, addr_d;
  logic                         busy_q, busy_d;
  int                           n_eff, n_win;

  always_comb begin
    for (int i = 0; i < FU_NUM; i++) begin
      data_a[i]  = req_data[i*WORD_SIZE +: WORD_SIZE];
      addr_a[i]  = req_addr[i*WORD_SIZE +: WORD_SIZE];
      rbidx_a[i] = req_rbidx[i*RB_INDEX +: RB_INDEX];
    end
    eff = reset ? '0 : (req & ~flush);
  end

  cdb_arbiter_rr_picker #(.N(FU_NUM), .IW(FU_INDEX)) u_pick0 (
    .req_i   (eff),
    .start_i (rr_ptr_q),
    .excl_i  ({FU_NUM{1'b0}}),
    .gnt_o   (g0),
    .found_o (f0)
  );

  always_comb begin
    rb0    = '0;
    d0     = '0;
    a0     = '0;
    start1 = rr_ptr_q;
    for (int i = 0; i < FU_NUM; i++) begin
      if (g0[i]) begin
        rb0    = rbidx_a[i];
        d0     = data_a[i];
        a0     = addr_a[i];
        start1 = FU_INDEX'(rr_next(i, FU_NUM));
      end
    end
  end

  generate
    if (CDB_PORTS == 2) begin : g_port1
      logic [FU_NUM-1:0] excl1;

      // Port 1 never takes the port-0 winner nor a second result for the same RB slot.
      always_comb begin
        for (int i = 0; i < FU_NUM; i++) begin
          excl1[i] = ~f0 | g0[i] | (rbidx_a[i] == rb0);
        end
      end

      cdb_arbiter_rr_picker #(.N(FU_NUM), .IW(FU_INDEX)) u_pick1 (
        .req_i   (eff),
        .start_i (start1),
        .excl_i  (excl1),
        .gnt_o   (g1),
        .found_o (f1)
      );
    end else begin : g_no_port1
      assign g1 = '0;
      assign f1 = 1'b0;
    end
  endgenerate

  always_comb begin
    rb1  = '0;
    d1   = '0;
    a1   = '0;
    nxt1 = rr_ptr_q;
    for (int i = 0; i < FU_NUM; i++) begin
      if (g1[i]) begin
        rb1  = rbidx_a[i];
        d1   = data_a[i];
        a1   = addr_a[i];
        nxt1 = FU_INDEX'(rr_next(i, FU_NUM));
      end
    end
  end

  assign grant = g0 | g1;

  always_comb begin
    valid_d = '0;
    data_d  = data_q;
    addr_d  = addr_q;
    for (int j = 0; j < RB_SIZE; j++) begin
      if (f0 && (rb0 == RB_INDEX'(j))) begin
        valid_d[j]                        = 1'b1;
        data_d[j*WORD_SIZE +: WORD_SIZE]  = d0;
        addr_d[j*WORD_SIZE +: WORD_SIZE]  = a0;
      end
      if (f1 && (rb1 == RB_INDEX'(j))) begin
        valid_d[j]                        = 1'b1;
        data_d[j*WORD_SIZE +: WORD_SIZE]  = d1;
        addr_d[j*WORD_SIZE +: WORD_SIZE]  = a1;
      end
    end
    n_eff    = $countones(eff);
    n_win    = int'(f0) + int'(f1);
    busy_d   = (n_eff > n_win);
    rr_ptr_d = f1 ? nxt1 : (f0 ? start1 : rr_ptr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= '0;
      valid_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
    end
  end

  assign CDB_data_valid = valid_q;
  assign CDB_data_data  = data_q;
  assign CDB_data_addr  = addr_q;
  assign cdb_busy       = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a single-port and a dual-port instance share
// stimulus; a vector table plus hand sequences check grants and broadcasts.
module tb_cdb_arbiter;

  localparam logic [23:0] RB_DEF = 24'o76543210;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   req, flush;
  logic [255:0] req_data, req_addr;
  logic [23:0]  req_rbidx;

  logic [7:0]   g1_o, g2_o, v1_o, v2_o;
  logic [255:0] d1_o, d2_o, a1_o, a2_o;
  logic         b1_o, b2_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  req;
    logic [7:0]  flush;
    logic [23:0] rb;
    logic [7:0]  gnt;
    logic [7:0]  vld;
    logic        busy;
    int          slot;
    int          fu;
  } vec_t;

  vec_t tv[14];

  always #5 clk = ~clk;

  cdb_arbiter #(.CDB_PORTS(1)) u1 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
    .req_rbidx(req_rbidx), .flush(flush), .grant(g1_o), .CDB_data_data(d1_o),
    .CDB_data_addr(a1_o), .CDB_data_valid(v1_o), .cdb_busy(b1_o)
  );

  cdb_arbiter #(.CDB_PORTS(2)) u2 (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_addr(req_addr),
    .req_rbidx(req_rbidx), .flush(flush), .grant(g2_o), .CDB_data_data(d2_o),
    .CDB_data_addr(a2_o), .CDB_data_valid(v2_o), .cdb_busy(b2_o)
  );

  function automatic logic [31:0] fu_data(input int i);
    return (i == 2) ? 32'h0000_1234 : (32'hD000_0000 + 32'(i));
  endfunction

  function automatic logic [31:0] fu_addr(input int i);
    return 32'hA000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] slot(input logic [255:0] bus, input int j);
    return bus[j*32 +: 32];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    flush     = '0;
    req_rbidx = RB_DEF;
    next_cycle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    tv[0]  = '{8'h04, 8'h00, 24'o76543510, 8'h04, 8'h00, 1'b0, -1, -1};
    tv[1]  = '{8'h00, 8'h00, 24'o76543510, 8'h00, 8'h20, 1'b0,  5,  2};
    tv[2]  = '{8'h00, 8'h00, RB_DEF,       8'h00, 8'h00, 1'b0, -1, -1};
    tv[3]  = '{8'h06, 8'h00, RB_DEF,       8'h02, 8'h00, 1'b0, -1, -1};
    tv[4]  = '{8'h04, 8'h00, RB_DEF,       8'h04, 8'h02, 1'b1,  1,  1};
    tv[5]  = '{8'h00, 8'h00, RB_DEF,       8'h00, 8'h04, 1'b0,  2,  2};
    tv[6]  = '{8'h02, 8'h02, RB_DEF,       8'h00, 8'h00, 1'b0, -1, -1};
    tv[7]  = '{8'h02, 8'h00, RB_DEF,       8'h02, 8'h00, 1'b0, -1, -1};
    tv[8]  = '{8'h00, 8'h02, RB_DEF,       8'h00, 8'h02, 1'b0,  1,  1};
    tv[9]  = '{8'h81, 8'h00, RB_DEF,       8'h80, 8'h00, 1'b0, -1, -1};
    tv[10] = '{8'h01, 8'h00, RB_DEF,       8'h01, 8'h80, 1'b1,  7,  7};
    tv[11] = '{8'h01, 8'h00, RB_DEF,       8'h01, 8'h01, 1'b0,  0,  0};
    tv[12] = '{8'h00, 8'h00, RB_DEF,       8'h00, 8'h01, 1'b0,  0,  0};
    tv[13] = '{8'h00, 8'h00, RB_DEF,       8'h00, 8'h00, 1'b0, -1, -1};

    for (int i = 0; i < 8; i++) begin
      req_data[i*32 +: 32] = fu_data(i);
      req_addr[i*32 +: 32] = fu_addr(i);
    end

    // Reset state, with requests present to show grant is held off.
    reset     = 1'b1;
    req       = 8'hFF;
    flush     = '0;
    req_rbidx = RB_DEF;
    next_cycle();
    next_cycle();
    chk("rst_grant_p1", 64'(g1_o), 64'h0);
    chk("rst_grant_p2", 64'(g2_o), 64'h0);
    chk("rst_valid", 64'(v1_o), 64'h0);
    chk("rst_busy", 64'(b1_o), 64'h0);
    chk("rst_data_zero", 64'(|d1_o), 64'h0);
    chk("rst_addr_zero", 64'(|a1_o), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Single-port vector table.
    for (int i = 0; i < 14; i++) begin
      req       = tv[i].req;
      flush     = tv[i].flush;
      req_rbidx = tv[i].rb;
      #1;
      chk($sformatf("tv%0d_grant", i), 64'(g1_o), 64'(tv[i].gnt));
      chk($sformatf("tv%0d_valid", i), 64'(v1_o), 64'(tv[i].vld));
      chk($sformatf("tv%0d_busy", i), 64'(b1_o), 64'(tv[i].busy));
      if (tv[i].slot >= 0) begin
        chk($sformatf("tv%0d_data", i), 64'(slot(d1_o, tv[i].slot)), 64'(fu_data(tv[i].fu)));
        chk($sformatf("tv%0d_addr", i), 64'(slot(a1_o, tv[i].slot)), 64'(fu_addr(tv[i].fu)));
      end
      next_cycle();
    end
    chk("slot5_retained", 64'(slot(d1_o, 5)), 64'h1234);

    // Round robin, each FU dropping its request once granted.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req = 8'hFF << k;
      #1;
      chk($sformatf("rr%0d_grant", k), 64'(g1_o), 64'(8'h01 << k));
      if (k > 0) chk($sformatf("rr%0d_valid", k), 64'(v1_o), 64'(8'h01 << (k - 1)));
      next_cycle();
    end
    req = '0;
    #1;
    chk("rr_last_valid", 64'(v1_o), 64'h80);
    next_cycle();
    req = 8'h81;
    #1;
    chk("rr_wrap_grant", 64'(g1_o), 64'h01);
    next_cycle();

    // Dual port: distinct RB slots, then a shared RB slot.
    do_reset();
    req       = 8'h09;
    req_rbidx = 24'o76546211;
    #1;
    chk("dp_both_grant", 64'(g2_o), 64'h09);
    next_cycle();
    req = '0;
    #1;
    chk("dp_both_valid", 64'(v2_o), 64'h42);
    chk("dp_slot1_data", 64'(slot(d2_o, 1)), 64'(fu_data(0)));
    chk("dp_slot6_data", 64'(slot(d2_o, 6)), 64'(fu_data(3)));
    chk("dp_slot6_addr", 64'(slot(a2_o, 6)), 64'(fu_addr(3)));
    next_cycle();
    #1;
    chk("dp_idle_valid", 64'(v2_o), 64'h00);
    req       = 8'h09;
    req_rbidx = 24'o76543213;
    #1;
    chk("dp_same_rb_grant", 64'(g2_o), 64'h01);
    next_cycle();
    req = 8'h08;
    #1;
    chk("dp_same_rb_second", 64'(g2_o), 64'h08);
    chk("dp_same_rb_valid0", 64'(v2_o), 64'h08);
    chk("dp_same_rb_data0", 64'(slot(d2_o, 3)), 64'(fu_data(0)));
    chk("dp_same_rb_busy", 64'(b2_o), 64'h1);
    next_cycle();
    req = '0;
    #1;
    chk("dp_same_rb_valid1", 64'(v2_o), 64'h08);
    chk("dp_same_rb_data1", 64'(slot(d2_o, 3)), 64'(fu_data(3)));
    chk("dp_busy_clear", 64'(b2_o), 64'h0);
    next_cycle();

    // Asynchronous reset while a broadcast is on the bus.
    do_reset();
    req = 8'h01;
    #1;
    chk("ar_grant", 64'(g1_o), 64'h01);
    next_cycle();
    req = '0;
    #1;
    chk("ar_valid_before", 64'(v1_o), 64'h01);
    #2;
    reset = 1'b1;
    req   = 8'h03;
    #1;
    chk("ar_valid_async", 64'(v1_o), 64'h00);
    chk("ar_grant_in_reset", 64'(g1_o), 64'h00);
    next_cycle();
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    #1;
    chk("ar_idle_grant", 64'(g1_o), 64'h00);
    next_cycle();
    chk("ar_idle_valid", 64'(v1_o), 64'h00);
    req = 8'h03;
    #1;
    chk("ar_first_grant", 64'(g1_o), 64'h01);
    next_cycle();
    req = '0;
    #1;
    chk("ar_first_valid", 64'(v1_o), 64'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
